emif_tx_responder: RTL and testbench

FPGA-side responder for asynchronous EMIF read cycles issued by the DSP: the return path complementing the EMIF receive registers. It synchronizes the DSP chip-select and output-enable strobes, captures the address, fetches one word from the internal register bank over a req/ack handshake, and drives the word onto the EMIF data pads through a tristate enable until the DSP releases the strobe. It sits between the EMIF pad ring and the register-bank read mux.

---
 rtl/emif_tx_responder_if.sv | 41 ++++
 rtl/emif_tx_responder.sv | 185 ++++++++++++++++++
 tb/tb_emif_tx_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/emif_tx_responder_if.sv
// emif_tx_responder_if: bundle of EMIF pad-side and register-bank-side signals
// for the EMIF read responder. The responder connects through the slave
// modport; the DSP pads and register bank (or a bench) use master.
interface emif_tx_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  // DSP pad side
  logic                  emif_cs_n_i;
  logic                  emif_oe_n_i;
  logic [ADDR_WIDTH-1:0] emif_addr_i;
  logic [DATA_WIDTH-1:0] emif_data_o;
  logic                  emif_data_oe_o;
  // register bank side
  logic                  rd_req_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  rd_ack_i;
  // status
  logic                  busy_o;
  logic                  err_o;
  logic                  err_clr_i;

  modport slave (
    input  emif_cs_n_i, emif_oe_n_i, emif_addr_i,
    output emif_data_o, emif_data_oe_o,
    output rd_req_o, rd_addr_o,
    input  rd_data_i, rd_ack_i,
    output busy_o, err_o,
    input  err_clr_i
  );

  modport master (
    output emif_cs_n_i, emif_oe_n_i, emif_addr_i,
    input  emif_data_o, emif_data_oe_o,
    input  rd_req_o, rd_addr_o,
    output rd_data_i, rd_ack_i,
    input  busy_o, err_o,
    output err_clr_i
  );
endinterface

// File: rtl/emif_tx_responder.sv
// emif_tx_responder: serves asynchronous DSP EMIF read cycles.
// Synchronizes CS/OE, fetches one word from the register bank over a req/ack
// handshake and drives it onto the pads until the DSP releases the strobe.
// Optional feature macro: EMIF_TX_TIMEOUT_EN (REQ timeout with sticky err_o).
module emif_tx_responder #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    SYNC_STEPS   = 2,
  parameter int                    TIMEOUT      = 15,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(16'hDEAD)
) (
  input logic                clk_i,
  input logic                reset_i,
  emif_tx_responder_if.slave bus
);
  // A single flop is not a synchronizer; clamp the depth to at least 2.
  localparam int SYNC_N = (SYNC_STEPS < 2) ? 2 : SYNC_STEPS;

  typedef enum logic [1:0] {IDLE, REQ, DRIVE} state_t;

  state_t                state;
  logic [SYNC_N-1:0]     cs_sync;
  logic [SYNC_N-1:0]     oe_sync;
  logic                  s_act;
  logic                  s_act_d;
  logic                  start;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_oe_q;
  logic                  rd_req_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  busy_q;

  // Strobes are synchronized in active-high form so reset (all zero) means
  // "strobe inactive" and a strobe held through reset is seen as a fresh edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_sync <= '0;
      oe_sync <= '0;
      s_act_d <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_N-2:0], ~bus.emif_cs_n_i};
      oe_sync <= {oe_sync[SYNC_N-2:0], ~bus.emif_oe_n_i};
      s_act_d <= s_act;
    end
  end

  assign s_act = cs_sync[SYNC_N-1] & oe_sync[SYNC_N-1];
  // Rising edge only: a strobe held after a read never retriggers.
  assign start = s_act & ~s_act_d;

`ifdef EMIF_TX_TIMEOUT_EN
  localparam int TO_N  = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CNT_W = $clog2(TO_N + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // Read FSM with timeout; counter counts completed REQ cycles, the
  // TO_N-th REQ cycle without ack substitutes TIMEOUT_DATA.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      data_q    <= '0;
      data_oe_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      to_cnt    <= '0;
      err_q     <= 1'b0;
    end else begin
      // clear first so a timeout set later in this block wins
      if (bus.err_clr_i) err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            busy_q    <= 1'b1;
            rd_req_q  <= 1'b1;
            rd_addr_q <= bus.emif_addr_i;
            to_cnt    <= '0;
          end
        end
        REQ: begin
          if (!s_act) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            rd_req_q <= 1'b0;
          end else if (bus.rd_ack_i) begin
            state     <= DRIVE;
            data_q    <= bus.rd_data_i;
            data_oe_q <= 1'b1;
            rd_req_q  <= 1'b0;
          end else if (to_cnt == CNT_W'(TO_N - 1)) begin
            state     <= DRIVE;
            data_q    <= TIMEOUT_DATA;
            data_oe_q <= 1'b1;
            rd_req_q  <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (!s_act) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            data_oe_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          rd_req_q  <= 1'b0;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.err_o = err_q;
`else
  // Read FSM without timeout: REQ waits for ack or DSP abort.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      data_q    <= '0;
      data_oe_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            busy_q    <= 1'b1;
            rd_req_q  <= 1'b1;
            rd_addr_q <= bus.emif_addr_i;
          end
        end
        REQ: begin
          if (!s_act) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            rd_req_q <= 1'b0;
          end else if (bus.rd_ack_i) begin
            state     <= DRIVE;
            data_q    <= bus.rd_data_i;
            data_oe_q <= 1'b1;
            rd_req_q  <= 1'b0;
          end
        end
        DRIVE: begin
          if (!s_act) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            data_oe_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          rd_req_q  <= 1'b0;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // Timeout hardware absent: error flag tied low, clear and timeout knobs unused.
  logic                  unused_err_clr;
  logic [DATA_WIDTH-1:0] unused_timeout_cfg;
  assign unused_err_clr     = bus.err_clr_i;
  assign unused_timeout_cfg = TIMEOUT_DATA ^ DATA_WIDTH'(TIMEOUT);
  assign bus.err_o          = 1'b0;
`endif

  assign bus.emif_data_o    = data_q;
  assign bus.emif_data_oe_o = data_oe_q;
  assign bus.rd_req_o       = rd_req_q;
  assign bus.rd_addr_o      = rd_addr_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_emif_tx_responder.sv
// tb_emif_tx_responder: directed bench with a register-bank model and a
// scoreboard of expected {address, word} pairs popped at each pad-drive start.
module tb_emif_tx_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emif_tx_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus();

  emif_tx_responder dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   req_rises = 0;

  // bank model controls
  logic        bank_en = 1'b0;
  int          ack_dly = 0;
  logic        man_ack = 1'b0;
  logic [15:0] man_data = '0;

  function automatic logic [15:0] bank_word(input logic [7:0] a);
    if (a == 8'h3A) return 16'h1234;
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for rd_req_o (which=0) or emif_data_oe_o (which=1), bounded
  task automatic wait_for(input int which, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? bus.rd_req_o : bus.emif_data_oe_o) !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic strobe(input logic on, input logic [7:0] a);
    bus.emif_addr_i = a;
    bus.emif_cs_n_i = ~on;
    bus.emif_oe_n_i = ~on;
  endtask

  // register bank: acks ack_dly cycles after seeing rd_req_o, or follows man_ack
  int wait_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (bank_en) begin
      bus.rd_ack_i = 1'b0;
      if (bus.rd_req_o) begin
        if (wait_cnt == ack_dly) begin
          bus.rd_ack_i  = 1'b1;
          bus.rd_data_i = bank_word(bus.rd_addr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end else begin
      bus.rd_ack_i  = man_ack;
      bus.rd_data_i = man_data;
      wait_cnt = 0;
    end
  end

  // scoreboard pop on each pad-drive rising edge; count request rises
  logic prev_oe = 1'b0;
  logic prev_req = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.emif_data_oe_o === 1'b1 && prev_oe !== 1'b1) begin
      if (sb.size() == 0) chk("unexpected_drive", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_data", 32'(bus.emif_data_o), 32'(e.data));
        chk("sb_addr", 32'(bus.rd_addr_o), 32'(e.addr));
      end
    end
    if (bus.rd_req_o === 1'b1 && prev_req !== 1'b1) req_rises++;
    prev_oe  = bus.emif_data_oe_o;
    prev_req = bus.rd_req_o;
  end

  initial begin
    int r0;
    strobe(1'b0, 8'h00);
    bus.err_clr_i = 1'b0;
    bus.rd_ack_i  = 1'b0;
    bus.rd_data_i = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_oe",   32'(bus.emif_data_oe_o), 32'd0);
    chk("rst_data", 32'(bus.emif_data_o),    32'd0);
    chk("rst_req",  32'(bus.rd_req_o),       32'd0);
    chk("rst_addr", 32'(bus.rd_addr_o),      32'd0);
    chk("rst_busy", 32'(bus.busy_o),         32'd0);
    chk("rst_err",  32'(bus.err_o),          32'd0);

    // basic read: addr 3A, ack 2 cycles after req, strobe low 12 cycles
    bank_en = 1'b1;
    ack_dly = 2;
    sb.push_back('{8'h3A, 16'h1234});
    strobe(1'b1, 8'h3A);
    tick(); tick();
    chk("lat_req_pre", 32'(bus.rd_req_o), 32'd0);
    tick();
    chk("lat_req", 32'(bus.rd_req_o), 32'd1);
    chk("lat_addr", 32'(bus.rd_addr_o), 32'h3A);
    chk("lat_busy", 32'(bus.busy_o), 32'd1);
    repeat (9) tick();
    chk("t1_oe_held", 32'(bus.emif_data_oe_o), 32'd1);
    strobe(1'b0, 8'h3A);
    tick(); tick();
    chk("rel_oe_2", 32'(bus.emif_data_oe_o), 32'd1);
    tick();
    chk("rel_oe_3", 32'(bus.emif_data_oe_o), 32'd0);
    chk("rel_data_kept", 32'(bus.emif_data_o), 32'h1234);
    chk("rel_busy", 32'(bus.busy_o), 32'd0);
    repeat (3) tick();

    // strobe held 45 cycles: exactly one request
    ack_dly = 0;
    r0 = req_rises;
    sb.push_back('{8'h44, bank_word(8'h44)});
    strobe(1'b1, 8'h44);
    repeat (45) tick();
    chk("hold_one_req", 32'(req_rises - r0), 32'd1);
    chk("hold_oe", 32'(bus.emif_data_oe_o), 32'd1);
    chk("hold_req_low", 32'(bus.rd_req_o), 32'd0);
    strobe(1'b0, 8'h44);
    repeat (5) tick();

    // abort: strobe released while rd_req_o high; ack coincides with abort
    bank_en = 1'b0;
    man_data = 16'hBEEF;
    strobe(1'b1, 8'h55);
    wait_for(0, "abort_req_seen");
    strobe(1'b0, 8'h55);
    tick();
    chk("abort_req_still", 32'(bus.rd_req_o), 32'd1);
    tick();
    man_ack = 1'b1;
    tick();
    chk("abort_req", 32'(bus.rd_req_o), 32'd0);
    chk("abort_oe", 32'(bus.emif_data_oe_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    tick();
    man_ack = 1'b0;
    tick();
    chk("abort_oe_late_ack", 32'(bus.emif_data_oe_o), 32'd0);
    chk("abort_busy_late", 32'(bus.busy_o), 32'd0);
    repeat (3) tick();

`ifdef EMIF_TX_TIMEOUT_EN
    // timeout: no ack for 15 REQ cycles
    strobe(1'b1, 8'h77);
    wait_for(0, "to_req_seen");
    sb.push_back('{8'h77, 16'hDEAD});
    repeat (14) tick();
    chk("to_req_14", 32'(bus.rd_req_o), 32'd1);
    tick();
    chk("to_req", 32'(bus.rd_req_o), 32'd0);
    chk("to_oe", 32'(bus.emif_data_oe_o), 32'd1);
    chk("to_data", 32'(bus.emif_data_o), 32'hDEAD);
    chk("to_err", 32'(bus.err_o), 32'd1);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    chk("to_err_clr", 32'(bus.err_o), 32'd0);
    strobe(1'b0, 8'h77);
    repeat (5) tick();
`else
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    chk("err_const", 32'(bus.err_o), 32'd0);
`endif

    // reset during DRIVE
    bank_en = 1'b1;
    ack_dly = 1;
    sb.push_back('{8'h10, bank_word(8'h10)});
    strobe(1'b1, 8'h10);
    wait_for(1, "rd_drive_seen");
    tick();
    rst = 1'b1;
    strobe(1'b0, 8'h10);
    tick();
    chk("rd_oe", 32'(bus.emif_data_oe_o), 32'd0);
    chk("rd_data", 32'(bus.emif_data_o), 32'd0);
    chk("rd_req", 32'(bus.rd_req_o), 32'd0);
    chk("rd_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    sb.push_back('{8'h20, bank_word(8'h20)});
    strobe(1'b1, 8'h20);
    repeat (10) tick();
    chk("post_rst_oe", 32'(bus.emif_data_oe_o), 32'd1);
    strobe(1'b0, 8'h20);
    repeat (5) tick();

    // back-to-back reads with 3 idle cycles
    ack_dly = 0;
    sb.push_back('{8'h01, bank_word(8'h01)});
    strobe(1'b1, 8'h01);
    repeat (10) tick();
    chk("b2b_oe1", 32'(bus.emif_data_oe_o), 32'd1);
    strobe(1'b0, 8'h01);
    repeat (3) tick();
    chk("b2b_gap_oe", 32'(bus.emif_data_oe_o), 32'd0);
    sb.push_back('{8'h02, bank_word(8'h02)});
    strobe(1'b1, 8'h02);
    repeat (10) tick();
    chk("b2b_oe2", 32'(bus.emif_data_oe_o), 32'd1);
    chk("b2b_data2", 32'(bus.emif_data_o), 32'(bank_word(8'h02)));
    strobe(1'b0, 8'h02);
    repeat (5) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
